// File: rtl/mem_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_bridge
//  Description : Memory-stage bus bridge. Routes one request at a time to a
//                one-hot selected target (RAM, frame buffer, camera control,
//                I/O), sequences wait-state handshakes with a timeout, and
//                returns read data / fault status with a stall handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_bridge #(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [3:0]        WAIT_MASK  = 4'b0010,
  parameter int unsigned       TIMEOUT    = 15,
  parameter logic [DATA_W-1:0] FAULT_DATA = 32'hDEADBEEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [DATA_W-1:0] address_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        mem_select_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              bus_fault_o,
  output logic [3:0]        tgt_en_o,
  output logic              tgt_we_o,
  output logic [DATA_W-1:0] tgt_addr_o,
  output logic [DATA_W-1:0] tgt_wdata_o,
  input  logic [DATA_W-1:0] tgt_rdata0_i,
  input  logic [DATA_W-1:0] tgt_rdata1_i,
  input  logic [DATA_W-1:0] tgt_rdata2_i,
  input  logic [DATA_W-1:0] tgt_rdata3_i,
  input  logic [3:0]        tgt_ready_i
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  // Value of the counter during the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              w_onehot;
  logic              w_is_wait;
  logic              w_ready;
  logic [DATA_W-1:0] w_tgt_rdata;

  // Decode helpers: one-hot check on the incoming select, target class and
  // readiness of the latched target, and an AND-OR read-data mux.
  always_comb begin
    w_onehot    = (mem_select_i != 4'b0000) &&
                  ((mem_select_i & (mem_select_i - 4'd1)) == 4'b0000);
    w_is_wait   = |(sel_q & WAIT_MASK);
    w_ready     = |(sel_q & tgt_ready_i);
    w_tgt_rdata = ({DATA_W{sel_q[0]}} & tgt_rdata0_i) |
                  ({DATA_W{sel_q[1]}} & tgt_rdata1_i) |
                  ({DATA_W{sel_q[2]}} & tgt_rdata2_i) |
                  ({DATA_W{sel_q[3]}} & tgt_rdata3_i);
  end

  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    sel_d         = sel_q;
    fault_d       = fault_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    stall_o       = 1'b0;
    tgt_en_o      = 4'b0000;
    rdata_valid_o = 1'b0;
    bus_fault_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          stall_o = 1'b1;
          we_d    = req_we_i;
          addr_d  = address_i;
          wdata_d = wdata_i;
          sel_d   = mem_select_i;
          cnt_d   = '0;
          if (w_onehot) begin
            fault_d = 1'b0;
            state_d = ACCESS;
          end else begin
            // Unmapped or ambiguous select: fault without touching any target.
            fault_d = 1'b1;
            if (!req_we_i) rdata_d = FAULT_DATA;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        stall_o  = 1'b1;
        tgt_en_o = sel_q;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Ready takes priority over the timeout in the final cycle.
        if (!w_is_wait || w_ready) begin
          if (!we_q) rdata_d = w_tgt_rdata;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          if (!we_q) rdata_d = FAULT_DATA;
          state_d = RESP;
        end
      end
      RESP: begin
        rdata_valid_o = !we_q;
        bus_fault_o   = fault_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Latched request, fault flag, wait counter and returned read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= 4'b0000;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign tgt_we_o    = we_q;
  assign tgt_addr_o  = addr_q;
  assign tgt_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_bridge
//  Description : Directed, table-driven bench for mem_bus_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [31:0] address, wdata;
  logic [3:0]  mem_select;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, bus_fault;
  logic [3:0]  tgt_en;
  logic        tgt_we;
  logic [31:0] tgt_addr, tgt_wdata;
  logic [31:0] tgt_rdata0, tgt_rdata1, tgt_rdata2, tgt_rdata3;
  logic [3:0]  tgt_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_bridge #(
    .DATA_W(32), .WAIT_MASK(4'b0010), .TIMEOUT(15), .FAULT_DATA(32'hDEADBEEF)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_we_i(req_we),
    .address_i(address), .wdata_i(wdata), .mem_select_i(mem_select),
    .stall_o(stall), .rdata_o(rdata), .rdata_valid_o(rdata_valid),
    .bus_fault_o(bus_fault), .tgt_en_o(tgt_en), .tgt_we_o(tgt_we),
    .tgt_addr_o(tgt_addr), .tgt_wdata_o(tgt_wdata),
    .tgt_rdata0_i(tgt_rdata0), .tgt_rdata1_i(tgt_rdata1),
    .tgt_rdata2_i(tgt_rdata2), .tgt_rdata3_i(tgt_rdata3),
    .tgt_ready_i(tgt_ready)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] tdata;      // read data presented by the selected target
    int          rdy;        // ACCESS cycle on which ready rises (0 = never)
    int          exp_stall;  // cycles with stall high
    logic [31:0] exp_rdata;
    logic        exp_valid;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] sel,
                              input logic [31:0] td, input int rdy,
                              input int es, input logic [31:0] er,
                              input logic ev, input logic ef);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.sel = sel; v.tdata = td;
    v.rdy = rdy; v.exp_stall = es; v.exp_rdata = er;
    v.exp_valid = ev; v.exp_fault = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Selected targets present tdata; unselected ones present distinct junk.
  task automatic drive_tdata(input logic [3:0] sel, input logic [31:0] td);
    tgt_rdata0 = sel[0] ? td : ~td;
    tgt_rdata1 = sel[1] ? td : ~td ^ 32'h1;
    tgt_rdata2 = sel[2] ? td : ~td ^ 32'h2;
    tgt_rdata3 = sel[3] ? td : ~td ^ 32'h3;
  endtask

  // One transaction; req_valid stays high through the response cycle to
  // show the bridge ignores it there, and the next request follows at once.
  task automatic run_txn(input vec_t v, input int idx);
    int stalls;
    int acc;
    bit done;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    address    = v.addr;
    wdata      = v.wdata;
    mem_select = v.sel;
    tgt_ready  = 4'b0000;
    drive_tdata(v.sel, v.tdata);
    #1;
    check($sformatf("v%0d accept stall", idx), {31'b0, stall}, 32'd1);
    check($sformatf("v%0d accept tgt_en", idx), {28'b0, tgt_en}, 32'd0);
    stalls = 1;
    acc    = 0;
    done   = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      acc++;
      tgt_ready = (acc == v.rdy) ? v.sel : 4'b0000;
      #1;
      if (stall) begin
        stalls++;
        check($sformatf("v%0d access tgt_en", idx), {28'b0, tgt_en}, {28'b0, v.sel});
        check($sformatf("v%0d access tgt_we", idx), {31'b0, tgt_we}, {31'b0, v.we});
        check($sformatf("v%0d access tgt_addr", idx), tgt_addr, v.addr);
        check($sformatf("v%0d access tgt_wdata", idx), tgt_wdata, v.wdata);
        check($sformatf("v%0d access valid/fault", idx),
              {30'b0, rdata_valid, bus_fault}, 32'd0);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL v%0d timeout: stall still high after %0d cycles, expected release", idx, stalls);
    end
    check($sformatf("v%0d stall cycles", idx), stalls, v.exp_stall);
    check($sformatf("v%0d rdata_valid", idx), {31'b0, rdata_valid}, {31'b0, v.exp_valid});
    check($sformatf("v%0d bus_fault", idx), {31'b0, bus_fault}, {31'b0, v.exp_fault});
    check($sformatf("v%0d resp tgt_en", idx), {28'b0, tgt_en}, 32'd0);
    check($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
    tgt_ready = 4'b0000;
  endtask

  initial begin
    //          we    addr          wdata          sel      tdata         rdy st  exp_rdata     v     f
    vecs[0]  = mk(1'b0, 32'h00010, 32'h0,         4'b0001, 32'h12345678, 0,  2,  32'h12345678, 1'b1, 1'b0);
    vecs[1]  = mk(1'b1, 32'h60000, 32'hCAFE0001,  4'b0100, 32'h77777777, 0,  2,  32'h12345678, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 32'h50000, 32'h0,         4'b0010, 32'hA5A5A5A5, 4,  5,  32'hA5A5A5A5, 1'b1, 1'b0);
    vecs[3]  = mk(1'b0, 32'h50004, 32'h0,         4'b0010, 32'h01020304, 0,  16, 32'hDEADBEEF, 1'b1, 1'b1);
    vecs[4]  = mk(1'b0, 32'h50008, 32'h0,         4'b0010, 32'h5A5A0F0F, 15, 16, 32'h5A5A0F0F, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 32'h90000, 32'h0,         4'b0000, 32'h22222222, 0,  1,  32'hDEADBEEF, 1'b1, 1'b1);
    vecs[6]  = mk(1'b0, 32'h90004, 32'h0,         4'b0011, 32'h11111111, 0,  1,  32'hDEADBEEF, 1'b1, 1'b1);
    vecs[7]  = mk(1'b0, 32'h70000, 32'h0,         4'b1000, 32'h13579BDF, 0,  2,  32'h13579BDF, 1'b1, 1'b0);
    vecs[8]  = mk(1'b1, 32'h90008, 32'h55AA55AA,  4'b0000, 32'h33333333, 0,  1,  32'h13579BDF, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 32'h5000C, 32'h0BB00BB0,  4'b0010, 32'h44444444, 1,  2,  32'h13579BDF, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 32'h50010, 32'hF00DF00D,  4'b0010, 32'h66666666, 0,  16, 32'h13579BDF, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 32'h60004, 32'h0,         4'b0100, 32'h0BADF00D, 0,  2,  32'h0BADF00D, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 32'h50014, 32'h0,         4'b0010, 32'h0F1E2D3C, 14, 15, 32'h0F1E2D3C, 1'b1, 1'b0);
    vecs[13] = mk(1'b1, 32'h90010, 32'h12121212,  4'b1100, 32'h88888888, 0,  1,  32'h0F1E2D3C, 1'b0, 1'b1);

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    address    = 32'h0;
    wdata      = 32'h0;
    mem_select = 4'b0000;
    tgt_ready  = 4'b0000;
    drive_tdata(4'b0000, 32'h0);

    // Reset state.
    @(negedge clk);
    #1;
    check("reset stall", {31'b0, stall}, 32'd0);
    check("reset tgt_en", {28'b0, tgt_en}, 32'd0);
    check("reset valid/fault/we", {29'b0, rdata_valid, bus_fault, tgt_we}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset tgt_addr", tgt_addr, 32'd0);
    check("reset tgt_wdata", tgt_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no request: no stall.
    @(negedge clk);
    #1;
    check("idle stall", {31'b0, stall}, 32'd0);

    for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

    // Reset in the middle of a frame-buffer wait.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    address    = 32'h50020;
    mem_select = 4'b0010;
    tgt_ready  = 4'b0000;
    drive_tdata(4'b0010, 32'h99999999);
    repeat (3) @(negedge clk);
    #1;
    check("midwait tgt_en", {28'b0, tgt_en}, 32'd2);
    check("midwait stall", {31'b0, stall}, 32'd1);
    #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("async reset tgt_en", {28'b0, tgt_en}, 32'd0);
    check("async reset stall", {31'b0, stall}, 32'd0);
    check("async reset rdata", rdata, 32'd0);
    check("async reset tgt_addr", tgt_addr, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("in reset valid/fault", {30'b0, rdata_valid, bus_fault}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post reset valid/fault", {30'b0, rdata_valid, bus_fault}, 32'd0);
    run_txn(mk(1'b0, 32'h00020, 32'h0, 4'b0001, 32'hFEEDFACE, 0, 2,
               32'hFEEDFACE, 1'b1, 1'b0), 100);

    // Quiet cycle after the last response: rdata holds, no pulses.
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("hold stall", {31'b0, stall}, 32'd0);
    check("hold valid/fault", {30'b0, rdata_valid, bus_fault}, 32'd0);
    check("hold rdata", rdata, 32'hFEEDFACE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
